// File: rtl/mips_cpu_regfile_sb.sv
// mips_cpu_regfile_sb
//   MIPS general-purpose register file with HI/LO pair and a per-register
//   scoreboard tracking writes still owed by multi-cycle producers.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   - a same-cycle GPR/HI/LO write is forwarded to the read ports,
//                 and a forwarded GPR read reports not-busy unless it is being
//                 re-marked in the same cycle.
//     undefined - reads return stored contents only.
//
//   Ports
//     clk, reset        clock, synchronous active-high reset
//     rs_idx/rs_data    read port A (combinational), index 0 reads 0
//     rt_idx/rt_data    read port B (combinational), index 0 reads 0
//     wr_en/wr_idx/wr_data      GPR write; also clears the scoreboard bit
//     hilo_wr_en/hi_wr/lo_wr    HI/LO write
//     hi_data/lo_data           HI/LO contents
//     pend_set/pend_idx         mark a GPR busy
//     rs_busy/rt_busy           scoreboard state of rs_idx/rt_idx
//     pend_count                number of busy GPRs
//     reg_v0                    contents of GPR V0_IDX
module mips_cpu_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int V0_IDX = 2,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rs_idx,
  output logic [DATA_W-1:0] rs_data,
  input  logic [AW-1:0]     rt_idx,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hilo_wr_en,
  input  logic [DATA_W-1:0] hi_wr,
  input  logic [DATA_W-1:0] lo_wr,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data,
  input  logic              pend_set,
  input  logic [AW-1:0]     pend_idx,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [CW-1:0]     pend_count,
  output logic [DATA_W-1:0] reg_v0
);

  localparam logic [AW-1:0] V0_SEL = AW'(V0_IDX);

  logic [DATA_W-1:0] gpr [NREGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;

  logic gpr_wr;
  logic pend_wr;
  logic rs_hit;
  logic rt_hit;
  logic hilo_hit;

  function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) cnt = cnt + CW'(v[i]);
    return cnt;
  endfunction

  assign gpr_wr  = wr_en && (wr_idx != '0);
  assign pend_wr = pend_set && (pend_idx != '0);

`ifdef REGFILE_BYPASS_EN
  assign rs_hit   = gpr_wr && (wr_idx == rs_idx);
  assign rt_hit   = gpr_wr && (wr_idx == rt_idx);
  assign hilo_hit = hilo_wr_en;
`else
  assign rs_hit   = 1'b0;
  assign rt_hit   = 1'b0;
  assign hilo_hit = 1'b0;
`endif

  // Clear first, then set: a new issue on the index being retired wins.
  always_comb begin
    busy_nxt = busy;
    if (gpr_wr)  busy_nxt[wr_idx]   = 1'b0;
    if (pend_wr) busy_nxt[pend_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
      busy <= '0;
    end else begin
      if (gpr_wr) gpr[wr_idx] <= wr_data;
      if (hilo_wr_en) begin
        hi_q <= hi_wr;
        lo_q <= lo_wr;
      end
      busy <= busy_nxt;
    end
  end

  // Read ports are forced to 0 while reset is held, not just after the edge.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    hi_data = '0;
    lo_data = '0;
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    if (!reset) begin
      if (rs_idx != '0) rs_data = rs_hit ? wr_data : gpr[rs_idx];
      if (rt_idx != '0) rt_data = rt_hit ? wr_data : gpr[rt_idx];
      hi_data = hilo_hit ? hi_wr : hi_q;
      lo_data = hilo_hit ? lo_wr : lo_q;
      rs_busy = rs_hit ? (pend_wr && (pend_idx == rs_idx)) : busy[rs_idx];
      rt_busy = rt_hit ? (pend_wr && (pend_idx == rt_idx)) : busy[rt_idx];
    end
  end

  assign pend_count = popcount(busy);
  assign reg_v0     = gpr[V0_SEL];

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
module tb_mips_cpu_regfile_sb;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int V0_IDX = 2;
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     rs_idx, rt_idx, wr_idx, pend_idx;
  logic [DATA_W-1:0] rs_data, rt_data, wr_data, hi_wr, lo_wr, hi_data, lo_data, reg_v0;
  logic              wr_en, hilo_wr_en, pend_set, rs_busy, rt_busy;
  logic [CW-1:0]     pend_count;

  mips_cpu_regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .V0_IDX(V0_IDX)) dut (
    .clk(clk), .reset(reset),
    .rs_idx(rs_idx), .rs_data(rs_data), .rt_idx(rt_idx), .rt_data(rt_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .hilo_wr_en(hilo_wr_en), .hi_wr(hi_wr), .lo_wr(lo_wr),
    .hi_data(hi_data), .lo_data(lo_data),
    .pend_set(pend_set), .pend_idx(pend_idx),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .pend_count(pend_count), .reg_v0(reg_v0)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state as plain arrays.
  int unsigned m_gpr [NREGS];
  bit          m_busy [NREGS];
  int unsigned m_hi, m_lo;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    if (reset) return 0;
    if (idx == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_idx == idx) return wr_data;
`endif
    return m_gpr[idx];
  endfunction

  function automatic logic m_rbusy(input int idx);
    if (reset) return 0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && idx != 0 && wr_idx == idx) return pend_set && pend_idx == idx;
`endif
    return m_busy[idx];
  endfunction

  function automatic logic [31:0] m_hilo(input bit is_hi);
    if (reset) return 0;
`ifdef REGFILE_BYPASS_EN
    if (hilo_wr_en) return is_hi ? hi_wr : lo_wr;
`endif
    return is_hi ? m_hi : m_lo;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rs_data"}, rs_data, m_read(int'(rs_idx)));
    check({tag, ".rt_data"}, rt_data, m_read(int'(rt_idx)));
    check({tag, ".hi"}, hi_data, m_hilo(1));
    check({tag, ".lo"}, lo_data, m_hilo(0));
    check({tag, ".rs_busy"}, 32'(rs_busy), 32'(m_rbusy(int'(rs_idx))));
    check({tag, ".rt_busy"}, 32'(rt_busy), 32'(m_rbusy(int'(rt_idx))));
    check({tag, ".pend_count"}, 32'(pend_count), 32'(m_count()));
    check({tag, ".reg_v0"}, reg_v0, m_gpr[V0_IDX]);
  endtask

  // Apply one clock edge to both the DUT and the model.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin m_gpr[i] = 0; m_busy[i] = 0; end
      m_hi = 0; m_lo = 0;
    end else begin
      if (wr_en && wr_idx != 0) begin m_gpr[wr_idx] = wr_data; m_busy[wr_idx] = 0; end
      if (hilo_wr_en) begin m_hi = hi_wr; m_lo = lo_wr; end
      if (pend_set && pend_idx != 0) m_busy[pend_idx] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; hilo_wr_en = 0; pend_set = 0;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin m_gpr[i] = 0; m_busy[i] = 0; end
    m_hi = 0; m_lo = 0;
    reset = 1; idle();
    rs_idx = 0; rt_idx = 0; wr_idx = 0; pend_idx = 0;
    wr_data = 0; hi_wr = 0; lo_wr = 0;
    @(negedge clk);
    tick();
    tick();
    #1 check_all("reset");
    check("reset.pend_count_const", 32'(pend_count), 0);

    // GPR 5 write, visible next cycle; index 0 reads 0
    reset = 0;
    wr_en = 1; wr_idx = 5; wr_data = 32'hDEADBEEF; rs_idx = 5; rt_idx = 0;
    #1 check_all("wr5_same");
    tick(); idle();
    #1 check_all("wr5_next");
    check("wr5.rs_const", rs_data, 32'hDEADBEEF);
    check("wr5.rt0_const", rt_data, 0);

    // write to GPR 0 is dropped; reg_v0 follows GPR 2
    wr_en = 1; wr_idx = 0; wr_data = 32'h12345678; rs_idx = 0;
    tick(); idle();
    #1 check("r0.rs_const", rs_data, 0);
    check("r0.v0_const", reg_v0, 0);
    wr_en = 1; wr_idx = 2; wr_data = 32'h7;
    tick(); idle();
    #1 check("v0.const", reg_v0, 32'h7);
    check_all("v0");

    // scoreboard set/clear
    pend_set = 1; pend_idx = 3; tick(); idle();
    #1 check("pend3.count", 32'(pend_count), 1);
    pend_set = 1; pend_idx = 7; tick(); idle();
    rs_idx = 3;
    #1 check("pend7.count", 32'(pend_count), 2);
    check("pend3.rs_busy", 32'(rs_busy), 1);
    wr_en = 1; wr_idx = 3; wr_data = 32'h33; tick(); idle();
    #1 check("clr3.count", 32'(pend_count), 1);
    check("clr3.rs_busy", 32'(rs_busy), 0);

    // simultaneous set and clear on 4, then re-mark already busy 4
    pend_set = 1; pend_idx = 4; wr_en = 1; wr_idx = 4; wr_data = 32'h44; tick(); idle();
    rs_idx = 4;
    #1 check("setclr4.count", 32'(pend_count), 2);
    check("setclr4.busy", 32'(rs_busy), 1);
    pend_set = 1; pend_idx = 4; tick(); idle();
    #1 check("reset4.count", 32'(pend_count), 2);
    check_all("sb");

    // write GPR 9 with rs_idx=9: forwarded only with the bypass build
    wr_en = 1; wr_idx = 9; wr_data = 32'hA5A5A5A5; rs_idx = 9;
`ifdef REGFILE_BYPASS_EN
    #1 check("byp9.same", rs_data, 32'hA5A5A5A5);
`else
    #1 check("byp9.same", rs_data, 0);
`endif
    tick(); idle();
    #1 check("byp9.next", rs_data, 32'hA5A5A5A5);

    // HI/LO
    hilo_wr_en = 1; hi_wr = 32'h1; lo_wr = 32'h2;
    #1 check_all("hilo_same");
    tick(); idle();
    #1 check("hilo.hi", hi_data, 32'h1);
    check("hilo.lo", lo_data, 32'h2);

    // reset with busy registers drops all marks; reset overrides strobes
    pend_set = 1; pend_idx = 10; tick();
    pend_idx = 11; tick();
    pend_idx = 12; tick(); idle();
    rs_idx = 10; rt_idx = 11;
    #1 check("busy3.count", 32'(pend_count), 5);
    reset = 1; wr_en = 1; wr_idx = 6; wr_data = 32'hFFFF0000;
    hilo_wr_en = 1; pend_set = 1; pend_idx = 13;
    #1 check_all("in_reset");
    tick(); idle();
    #1 check_all("after_reset");
    check("rst.count", 32'(pend_count), 0);
    check("rst.hi", hi_data, 0);
    reset = 0; wr_en = 1; wr_idx = 10; wr_data = 32'h10; tick(); idle();
    #1 check("rst.wr10.count", 32'(pend_count), 0);

    // randomized traffic against the model; low indices favoured for collisions
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 40) == 0);
      wr_en      = $urandom_range(0, 1);
      hilo_wr_en = ($urandom_range(0, 3) == 0);
      pend_set   = $urandom_range(0, 1);
      wr_idx     = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      pend_idx   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rs_idx     = ($urandom_range(0, 2) == 0) ? wr_idx : AW'($urandom_range(0, 7));
      rt_idx     = ($urandom_range(0, 2) == 0) ? pend_idx : AW'($urandom);
      wr_data    = $urandom;
      hi_wr      = $urandom;
      lo_wr      = $urandom;
      #1 check_all("rnd");
      tick();
    end
    reset = 0; idle();
    #1 check_all("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_regfile_sb.md
MIPS_CPU_REGFILE_SB -- requirements
Module: mips_cpu_regfile_sb

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: NREGS, 32, number of GPRs (power of two, 2..64).
REQ-003 Parameter: V0_IDX, 2, GPR index exported on reg_v0.
REQ-004 Derived: AW = $clog2(NREGS); CW = $clog2(NREGS+1).
REQ-005 Ports (reset: synchronous, active-high; clock: clk):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- rs_idx  in  AW  read port A index.
- rs_data  out  DATA_W  read port A data.
- rt_idx  in  AW  read port B index.
- rt_data  out  DATA_W  read port B data.
- wr_en  in  1  GPR write strobe.
- wr_idx  in  AW  GPR write index.
- wr_data  in  DATA_W  GPR write data.
- hilo_wr_en  in  1  HI/LO write strobe.
- hi_wr  in  DATA_W  HI write data.
- lo_wr  in  DATA_W  LO write data.
- hi_data  out  DATA_W  HI contents.
- lo_data  out  DATA_W  LO contents.
- pend_set  in  1  mark pend_idx busy (multi-cycle producer issued).
- pend_idx  in  AW  index to mark busy.
- rs_busy  out  1  rs_idx has an outstanding write.
- rt_busy  out  1  rt_idx has an outstanding write.
- pend_count  out  CW  number of busy GPRs.
- reg_v0  out  DATA_W  contents of GPR V0_IDX.

Function
REQ-006 rs_data/rt_data SHALL be combinational reads of the indexed GPR; index 0 SHALL always read 0.
REQ-007 On posedge clk with wr_en=1 and wr_idx!=0, GPR[wr_idx] SHALL take wr_data; writes to index 0 SHALL be discarded.
REQ-008 On posedge clk with hilo_wr_en=1, HI and LO SHALL take hi_wr and lo_wr in the same cycle; GPR and HI/LO writes SHALL be independent and may coincide.
REQ-009 Scoreboard: one busy bit per GPR; bit 0 SHALL be permanently 0.
REQ-010 pend_set=1, pend_idx!=0 SHALL set busy[pend_idx] at the edge; an already-busy bit SHALL stay set with pend_count unchanged.
REQ-011 wr_en=1, wr_idx!=0 SHALL clear busy[wr_idx] at the edge.
REQ-012 Simultaneous set and clear on the same index SHALL leave the bit set (new issue wins); on different indices both SHALL take effect.
REQ-013 pend_count SHALL equal the popcount of the busy bits, updated at the same edge; it SHALL never exceed NREGS-1.
REQ-014 rs_busy/rt_busy SHALL be combinational reads of busy[rs_idx]/busy[rt_idx].
REQ-015 reg_v0 SHALL continuously reflect GPR[V0_IDX].

Reset
REQ-016 With reset=1 at posedge clk, all GPRs, HI, LO and busy bits SHALL clear to 0 and pend_count SHALL be 0; reset SHALL override wr_en, hilo_wr_en and pend_set.
REQ-017 While reset=1, rs_data, rt_data, hi_data, lo_data, rs_busy and rt_busy SHALL read 0.
REQ-018 Reset asserted with registers busy SHALL drop all pending marks; a later write to a formerly busy index SHALL leave pend_count at 0.

Configuration
REQ-019 Macro: REGFILE_BYPASS_EN.
REQ-020 Defined: with wr_en=1, wr_idx!=0 and wr_idx equal to rs_idx (or rt_idx), rs_data (rt_data) SHALL return wr_data in that cycle, and rs_busy (rt_busy) SHALL read 0 unless pend_set targets the same index. With hilo_wr_en=1, hi_data/lo_data SHALL return hi_wr/lo_wr.
REQ-021 Undefined: reads SHALL return stored contents only; written values become visible the cycle after the write edge.

Verification
REQ-022 Reset, then write 0xDEADBEEF to GPR 5; next cycle rs_idx=5 -> rs_data=0xDEADBEEF; rt_idx=0 -> rt_data=0.
REQ-023 Write 0x12345678 to GPR 0 -> rs_idx=0 reads 0; reg_v0=0 until GPR 2 is written with 0x7, then reg_v0=0x7.
REQ-024 pend_set on 3, then on 7 -> pend_count 1, then 2; rs_idx=3 -> rs_busy=1; write GPR 3 -> pend_count=1, rs_busy=0.
REQ-025 Same cycle: pend_set idx 4 and wr_en idx 4 -> busy[4]=1, pend_count +1; pend_set on already-busy 4 -> count unchanged.
REQ-026 With REGFILE_BYPASS_EN: wr_en idx 9 data 0xA5A5A5A5, rs_idx=9 -> rs_data=0xA5A5A5A5 same cycle; without the macro -> old value this cycle, new value next cycle.
REQ-027 hilo_wr_en with hi_wr=0x1, lo_wr=0x2 -> hi_data=0x1, lo_data=0x2 next cycle; reset with 3 busy GPRs -> pend_count=0 and all outputs 0.
